final_soc_sw_poll_master: RTL and testbench



---
 rtl/final_soc_sw_poll_pkg.sv | 25 ++
 rtl/final_soc_sw_poll_debounce.sv | 80 ++++++++
 rtl/final_soc_sw_poll_master.sv | 135 +++++++++++++
 tb/tb_final_soc_sw_poll_master.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/final_soc_sw_poll_pkg.sv
// final_soc_sw_poll_pkg
//   Shared types and defaults for the switch-poll master.
//   - poll_state_e : poll FSM state encoding
//   - DEF_*        : default parameter values
//   - cnt_w()      : counter width helper (never returns 0)
package final_soc_sw_poll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } poll_state_e;

    localparam int DEF_DATA_W         = 10;
    localparam int DEF_POLL_DIV       = 50000;
    localparam int DEF_READ_LATENCY   = 1;
    localparam int DEF_STABLE_SAMPLES = 4;

    // Width needed to hold values 0..n-1, at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/final_soc_sw_poll_debounce.sv
// final_soc_sw_debounce
//   Debounces a stream of polled samples. A new value is accepted once
//   STABLE_SAMPLES consecutive identical samples have been seen and it
//   differs from the current state (or no value was accepted yet).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   sample_valid  : one-cycle strobe, sample is a fresh poll result
//   sample        : polled switch bits
//   state         : debounced switch vector
//   changed       : one-cycle pulse when state updates
//   valid         : high once the first value has been accepted
module final_soc_sw_debounce
    import final_soc_sw_poll_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] state,
    output logic              changed,
    output logic              valid
);

    localparam int                 MATCH_W   = cnt_w(STABLE_SAMPLES + 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(STABLE_SAMPLES);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

    logic [DATA_W-1:0]  cand_q,  cand_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [DATA_W-1:0]  state_q, state_d;
    logic               valid_q, valid_d;
    logic               changed_q, changed_d;

    always_comb begin
        cand_d    = cand_q;
        match_d   = match_q;
        state_d   = state_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        if (sample_valid) begin
            if (sample == cand_q) begin
                // saturate so long stable periods never wrap
                if (match_q != MATCH_MAX) match_d = match_q + MATCH_ONE;
            end else begin
                cand_d  = sample;
                match_d = MATCH_ONE;
            end
            // first acceptance always pulses, even for an all-zero value
            if (match_d == MATCH_MAX && (!valid_q || cand_d != state_q)) begin
                state_d   = cand_d;
                valid_d   = 1'b1;
                changed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q    <= '0;
            match_q   <= '0;
            state_q   <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            match_q   <= match_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign state   = state_q;
    assign changed = changed_q;
    assign valid   = valid_q;

endmodule

// File: rtl/final_soc_sw_poll_master.sv
// final_soc_sw_poll_master
//   Avalon-MM read initiator that periodically polls a switch PIO register
//   and presents a debounced switch vector to fabric logic.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   enable            : polling permitted when high
//   avm_address       : constant REG_ADDR
//   avm_read          : read request, held until waitrequest is low
//   avm_waitrequest   : slave stall
//   avm_readdata      : read data, low DATA_W bits used
//   sw_state          : debounced switch vector
//   sw_changed        : one-cycle pulse when sw_state updates
//   sw_valid          : high once the first value has been accepted
//   irq_ack, irq      : only with SW_POLL_IRQ_EN defined; irq is set by
//                       sw_changed and cleared by irq_ack (set wins)
// Build option: SW_POLL_IRQ_EN adds the interrupt output.
module final_soc_sw_poll_master
    import final_soc_sw_poll_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int POLL_DIV       = DEF_POLL_DIV,
    parameter int READ_LATENCY   = DEF_READ_LATENCY,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int REG_ADDR       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
`ifdef SW_POLL_IRQ_EN
    input  logic              irq_ack,
    output logic              irq,
`endif
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] sw_state,
    output logic              sw_changed,
    output logic              sw_valid
);

    localparam int               DIV_W      = cnt_w(POLL_DIV);
    localparam int               LAT_W      = cnt_w(READ_LATENCY);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(POLL_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LATENCY - 1);

    poll_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             sample_valid;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        lat_d        = lat_q;
        sample_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (div_q == '0) state_d = ST_REQ;
                    else             div_d   = div_q - DIV_W'(1);
                end
            end
            ST_REQ: begin
                // enable is deliberately ignored here: a posted read is
                // never withdrawn
                if (!avm_waitrequest) begin
                    state_d = ST_WAIT;
                    lat_d   = LAT_RELOAD;
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) state_d = ST_CAPTURE;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            ST_CAPTURE: begin
                sample_valid = 1'b1;
                div_d        = DIV_RELOAD;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_RELOAD;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            lat_q   <= lat_d;
        end
    end

    // Gated by reset so the request drops in the reset cycle itself.
    assign avm_read    = (state_q == ST_REQ) && !reset;
    assign avm_address = 2'(REG_ADDR);

    // Upper readdata bits are intentionally ignored.
    logic unused_readdata;
    assign unused_readdata = &{1'b0, avm_readdata};

    final_soc_sw_debounce #(
        .DATA_W         (DATA_W),
        .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (avm_readdata[DATA_W-1:0]),
        .state        (sw_state),
        .changed      (sw_changed),
        .valid        (sw_valid)
    );

`ifdef SW_POLL_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (irq_ack)    irq_d = 1'b0;
        if (sw_changed) irq_d = 1'b1;   // set beats a simultaneous ack
    end

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_final_soc_sw_poll_master.sv
// Scoreboard bench for final_soc_sw_poll_master (POLL_DIV=4, READ_LATENCY=1,
// STABLE_SAMPLES=4). A slave model answers each accepted read with the
// current physical switch value; a reference model debounces those values
// from a sliding window of recent samples and queues expected change events.
module tb_final_soc_sw_poll_master;

    localparam int DW     = 10;
    localparam int STABLE = 4;
    localparam int PERIOD = 7;   // POLL_DIV + 2 + READ_LATENCY

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    avm_address;
    logic          avm_read;
    logic          avm_waitrequest = 1'b0;
    logic [31:0]   avm_readdata = '0;
    logic [DW-1:0] sw_state;
    logic          sw_changed;
    logic          sw_valid;
`ifdef SW_POLL_IRQ_EN
    logic          irq_ack = 1'b0;
    logic          irq;
    logic          m_irq = 1'b0;
`endif

    always #5 clk = ~clk;

    final_soc_sw_poll_master #(
        .DATA_W(DW), .POLL_DIV(4), .READ_LATENCY(1),
        .STABLE_SAMPLES(STABLE), .REG_ADDR(0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
`ifdef SW_POLL_IRQ_EN
        .irq_ack         (irq_ack),
        .irq             (irq),
`endif
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .sw_state        (sw_state),
        .sw_changed      (sw_changed),
        .sw_valid        (sw_valid)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input bit ok, input string nm, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard state ----------------
    typedef struct { int due; logic [DW-1:0] val; } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] hist[$];
    logic [DW-1:0] m_state = '0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] sw_phys = '0;
    int            n_acc = 0;
    int            cyc = 0;

    // A captured sample enters the model: accept when the last STABLE
    // samples agree and differ from what is currently presented.
    task automatic commit(input logic [DW-1:0] v);
        bit same;
        hist.push_back(v);
        if (hist.size() > STABLE) void'(hist.pop_front());
        same = (hist.size() == STABLE);
        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
        if (same && (!m_valid || hist[0] != m_state)) begin
            m_state = hist[0];
            m_valid = 1'b1;
            exp_q.push_back('{due: cyc + 1, val: hist[0]});
        end
    endtask

    // ---------------- slave model + monitor (negedge) ----------------
    initial begin
        logic [31:0]   rd_word;
        logic [DW-1:0] pend_val;
        int            pend_cnt;
        int            last_acc;
        bit            rd_pending, clean, exp_chg;
        exp_t          e;
        rd_word = '0; pend_val = '0; pend_cnt = 0; last_acc = -1;
        rd_pending = 0; clean = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            exp_chg = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check(sw_changed == exp_chg, "sw_changed", sw_changed, exp_chg);
            if (exp_chg) begin
                e = exp_q.pop_front();
                check(sw_state == e.val, "changed_state", sw_state, e.val);
            end
            check(sw_state == m_state && sw_valid == m_valid, "state_valid",
                  {sw_valid, sw_state}, {m_valid, m_state});
            if (avm_read) check(avm_address == 2'd0, "avm_address", avm_address, 0);
`ifdef SW_POLL_IRQ_EN
            check(irq == m_irq, "irq", irq, m_irq);
            m_irq = exp_chg ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
`endif
            // read data appears one cycle after acceptance, even if reset hit
            if (rd_pending) begin
                avm_readdata = rd_word;
                rd_pending   = 0;
            end
            if (reset) begin
                exp_q.delete();
                hist.delete();
                m_state  = '0;
                m_valid  = 1'b0;
                pend_cnt = 0;
                last_acc = -1;
`ifdef SW_POLL_IRQ_EN
                m_irq = 1'b0;
`endif
            end else begin
                if (!enable || avm_waitrequest) clean = 0;
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) commit(pend_val);
                end
                if (avm_read && !avm_waitrequest) begin
                    if (last_acc >= 0 && clean)
                        check(cyc - last_acc == PERIOD, "poll_period", cyc - last_acc, PERIOD);
                    last_acc   = cyc;
                    clean      = 1;
                    rd_word    = $urandom();
                    rd_word[DW-1:0] = sw_phys;
                    pend_val   = sw_phys;
                    pend_cnt   = 2;
                    rd_pending = 1;
                    n_acc++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic poll_with(input logic [DW-1:0] v, input bit rnd);
        int start;
        bit got;
        sw_phys = v;
        start   = n_acc;
        got     = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(posedge clk); #2;
            if (rnd) begin
                avm_waitrequest = ($urandom_range(0, 3) == 0);
                enable          = ($urandom_range(0, 7) != 0);
`ifdef SW_POLL_IRQ_EN
                irq_ack         = ($urandom_range(0, 3) == 0);
`endif
            end
            if (n_acc != start) got = 1;
        end
        check(got, "poll_timeout", got, 1);
        if (rnd) begin
            avm_waitrequest = 1'b0;
            enable          = 1'b1;
`ifdef SW_POLL_IRQ_EN
            irq_ack         = 1'b0;
`endif
        end
    endtask

    task automatic stall_read();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #2;
            if (avm_read) seen = 1;
        end
        check(seen, "stall_wait_read", seen, 1);
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            check(avm_read == 1'b1 && avm_address == 2'd0, "stall_hold",
                  {avm_read, avm_address}, 3'b100);
        end
        avm_waitrequest = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] pool [4];
        logic [DW-1:0] v;
        int            hold;
        pool[0] = 10'h000; pool[1] = 10'h3FF; pool[2] = 10'h2A5; pool[3] = 10'h155;

        repeat (3) @(posedge clk);
        #2;
        check(sw_state == '0, "reset_sw_state", sw_state, 0);
        check(sw_valid == 1'b0, "reset_sw_valid", sw_valid, 0);
        check(sw_changed == 1'b0, "reset_sw_changed", sw_changed, 0);
        check(avm_read == 1'b0, "reset_avm_read", avm_read, 0);
        reset  = 1'b0;
        enable = 1'b1;

        // first accepted value is 0 and still pulses
        repeat (5) poll_with(10'h000, 0);
        // hold a new value
        repeat (6) poll_with(10'h2A5, 0);
        // glitch then return: no change expected
        poll_with(10'h2A5, 0);
        poll_with(10'h3FF, 0);
        repeat (4) poll_with(10'h2A5, 0);

        // waitrequest stall for 5 cycles, then finish acquiring a new value
        sw_phys = 10'h0F0;
        stall_read();
        repeat (5) poll_with(10'h0F0, 0);

        // reset while the read is in flight (WAIT state)
        poll_with(10'h133, 0);
        reset = 1'b1;
        @(posedge clk); #2;
        check(avm_read == 1'b0, "rst_wait_avm_read", avm_read, 0);
        check(sw_valid == 1'b0, "rst_wait_sw_valid", sw_valid, 0);
        check(sw_state == '0, "rst_wait_sw_state", sw_state, 0);
        reset = 1'b0;
        repeat (5) poll_with(10'h155, 0);

        // randomized holds with stalls, enable gaps and irq acks
        repeat (25) begin
            v    = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)]
                                                : 10'($urandom_range(0, 1023));
            hold = $urandom_range(1, 6);
            repeat (hold) poll_with(v, 1);
        end

        repeat (10) @(posedge clk);
        #2;
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
